indexed_address_unit: RTL and testbench
=======================================

# indexed_address_unit

Computes 65C02 indexed effective addresses (abs,X / abs,Y / zp,X / zp,Y) from operand bytes fetched on the data bus plus a snapshot of the X or Y index register. Sits directly downstream of index_register_X (and the matching Y register), consuming their `address_out` value. Its result feeds the address bus mux. A small state machine sequences the operand fetch, the low-byte add and the optional page-crossing fix-up cycle.

## Interface
No parameters.

- `fclk` in 1: single core clock; all state updates on its rising edge.
- `resb` in 1: reset, synchronous, active-low.
- `start` in 1: begin an address computation. Sampled only in IDLE.
- `mode` in 2: addressing mode, sampled with `start`.
  - 00 abs,X
  - 01 abs,Y
  - 10 zp,X
  - 11 zp,Y
- `index_x` in 8: X register `address_out`.
- `index_y` in 8: Y register `address_out`.
- `force_fixup` in 1: sampled with `start`. Forces the fix-up cycle on absolute modes even with no carry (RMW/store timing).
- `db_in` in 8: operand byte from the data bus.
- `db_valid` in 1: `db_in` holds the next operand byte this cycle.
- `ea` out 16: effective address. Holds its last value until the next DONE.
- `ea_valid` out 1: one-cycle pulse, high in DONE.
- `page_cross` out 1: low-byte add carried. Updated together with `ea`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, FIXUP, DONE.
- **IDLE**
  - If `start`: latch `mode` and `force_fixup`.
  - Snapshot the index: `index_x` for modes 00/10, `index_y` for 01/11.
  - Go to FETCH_LO.
  - Later changes on `index_x`/`index_y` are ignored until the next start.
- **FETCH_LO**
  - Wait while `db_valid`=0.
  - On `db_valid`, capture `lo` = `db_in`.
  - Zero-page modes: compute `sum8` = (`lo` + idx) mod 256, load `ea` = {8'h00, `sum8`}, `page_cross`=0, go to DONE. The carry is discarded (zero-page wrap).
  - Absolute modes: go to FETCH_HI.
- **FETCH_HI**
  - Wait while `db_valid`=0.
  - On `db_valid`, capture `hi` = `db_in` and compute 9-bit `s` = `lo` + idx.
  - If `s[8]` or `force_fixup`: go to FIXUP.
  - Otherwise load `ea` = {`hi`, `s[7:0]`}, `page_cross`=0, go to DONE.
- **FIXUP** (exactly one cycle)
  - Load `ea` = {(`hi` + `s[8]`) mod 256, `s[7:0]`} and `page_cross` = `s[8]`.
  - Go to DONE.
  - `hi`=FF with a carry wraps to 00, giving 16-bit address wrap.
- **DONE**
  - `ea_valid`=1.
  - Unconditionally go to IDLE. A `start` asserted during DONE is ignored.
- `start` outside IDLE is ignored. `db_valid` in IDLE or DONE is ignored.
- All arithmetic is unsigned 8-bit. The only carry ever used is `s[8]`.

## Timing
- Reset (`resb`=0 at a rising edge), from any state including mid-operation:
  - state goes to IDLE
  - `ea`=16'h0000, `ea_valid`=0, `page_cross`=0, `busy`=0
  - captured `lo`, `hi` and index are cleared
- `busy` is registered: it goes high the cycle after `start` is accepted and low in the cycle after DONE.
- Latency with `db_valid` continuously high (cycle 0 = `start` sampled in IDLE):
  - zero-page: `ea_valid` in cycle 2
  - absolute, no fix-up: `ea_valid` in cycle 3
  - absolute with fix-up: `ea_valid` in cycle 4
- Each cycle of `db_valid`=0 in FETCH_LO or FETCH_HI adds exactly one cycle of latency.
- `ea` and `page_cross` change only on the edge entering DONE. They are stable while `ea_valid`=1 and afterwards.
- Minimum start-to-start spacing is latency + 1 cycle, since DONE always returns to IDLE.

## Test plan
- abs,X, no carry: X=10, bytes 20 then 12, `db_valid` held high -> `ea`=1230, `page_cross`=0, `ea_valid` in cycle 3 only.
- abs,X with carry: X=FF, bytes 01 then 12 -> FIXUP cycle taken, `ea`=1300, `page_cross`=1, `ea_valid` in cycle 4.
- abs,Y 16-bit wrap: Y=20, bytes F0 then FF -> `ea`=0010, `page_cross`=1. zp,X wrap: X=20, byte F0 -> `ea`=0010, `page_cross`=0, `ea_valid` in cycle 2.
- `force_fixup`=1 on abs,X with X=01 and bytes 10, 40 -> `ea`=4011, `page_cross`=0, `ea_valid` in cycle 4.
- Stalls and snapshot: `db_valid` low for 2 cycles in FETCH_LO and 1 cycle in FETCH_HI, with X changed from 05 to 77 after start; bytes 00, 30 -> `ea`=3005, `ea_valid` in cycle 6. A `start` pulsed while busy has no effect.
- Reset mid-operation: `resb`=0 in FETCH_HI -> next cycle `busy`=0, `ea`=0000, no `ea_valid`. A new start then completes normally.

Source files
------------

// File: rtl/indexed_address_unit.sv
// indexed_address_unit: 65C02 indexed effective address (abs,X / abs,Y / zp,X / zp,Y) sequencer
module indexed_address_unit (
  input  logic        fclk,
  input  logic        resb,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  index_x,
  input  logic [7:0]  index_y,
  input  logic        force_fixup,
  input  logic [7:0]  db_in,
  input  logic        db_valid,
  output logic [15:0] ea,
  output logic        ea_valid,
  output logic        page_cross,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, FIXUP, DONE} state_t;
  state_t      state_q, state_d;
  logic        zp_q, zp_d;
  logic        ff_q, ff_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] ea_q, ea_d;
  logic        pc_q, pc_d;
  logic        ea_valid_q, busy_q;
  logic [7:0]  sum8;
  logic [8:0]  s;
  assign sum8 = db_in + idx_q;
  assign s = {1'b0, lo_q} + {1'b0, idx_q};
  // next-state and datapath loads; ea/page_cross only change on entry to DONE
  always_comb begin
    state_d = state_q;
    zp_d = zp_q;
    ff_d = ff_q;
    idx_d = idx_q;
    lo_d = lo_q;
    hi_d = hi_q;
    ea_d = ea_q;
    pc_d = pc_q;
    case (state_q)
      IDLE: if (start) begin
        zp_d = mode[1];
        ff_d = force_fixup;
        idx_d = mode[0] ? index_y : index_x;
        state_d = FETCH_LO;
      end
      FETCH_LO: if (db_valid) begin
        lo_d = db_in;
        if (zp_q) begin
          ea_d = {8'h00, sum8};
          pc_d = 1'b0;
          state_d = DONE;
        end else state_d = FETCH_HI;
      end
      FETCH_HI: if (db_valid) begin
        hi_d = db_in;
        if (s[8] || ff_q) state_d = FIXUP;
        else begin
          ea_d = {db_in, s[7:0]};
          pc_d = 1'b0;
          state_d = DONE;
        end
      end
      FIXUP: begin
        ea_d = {hi_q + {7'b0, s[8]}, s[7:0]};
        pc_d = s[8];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge fclk) begin
    if (!resb) begin
      state_q <= IDLE;
      zp_q <= 1'b0;
      ff_q <= 1'b0;
      idx_q <= 8'h00;
      lo_q <= 8'h00;
      hi_q <= 8'h00;
      ea_q <= 16'h0000;
      pc_q <= 1'b0;
      ea_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zp_q <= zp_d;
      ff_q <= ff_d;
      idx_q <= idx_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      ea_q <= ea_d;
      pc_q <= pc_d;
      ea_valid_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
    end
  end
  assign ea = ea_q;
  assign page_cross = pc_q;
  assign ea_valid = ea_valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_indexed_address_unit.sv
// tb_indexed_address_unit: scoreboard bench for indexed_address_unit
module tb_indexed_address_unit;
  logic fclk = 0, resb = 0, start = 0, force_fixup = 0, db_valid = 0;
  logic [1:0] mode = 0;
  logic [7:0] index_x = 0, index_y = 0, db_in = 0;
  logic [15:0] ea;
  logic ea_valid, page_cross, busy;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [15:0] ea; logic pc; int at;} exp_t;
  exp_t q[$];

  indexed_address_unit dut (
    .fclk(fclk), .resb(resb), .start(start), .mode(mode),
    .index_x(index_x), .index_y(index_y), .force_fixup(force_fixup),
    .db_in(db_in), .db_valid(db_valid), .ea(ea), .ea_valid(ea_valid),
    .page_cross(page_cross), .busy(busy)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge fclk);
    #1;
  endtask

  always @(negedge fclk) if (ea_valid === 1'b1) begin
    if (q.size() == 0) check("spurious_ea_valid", {31'b0, ea_valid}, 0);
    else begin
      exp_t e;
      e = q.pop_front();
      check("ea", {16'b0, ea}, {16'b0, e.ea});
      check("page_cross", {31'b0, page_cross}, {31'b0, e.pc});
      check("ea_valid_cycle", cyc, e.at);
    end
  end

  task automatic txn(input logic [1:0] m, input logic [7:0] x, y, x2, lo, hi,
                     input int sl, sh, input logic ff, sb,
                     input logic [15:0] xe, input logic xp, input int lat);
    int n;
    mode = m; index_x = x; index_y = y; force_fixup = ff; start = 1;
    q.push_back('{xe, xp, cyc + lat});
    step;
    start = 0; index_x = x2; index_y = ~y; force_fixup = ~ff; mode = ~m;
    check("busy_after_start", {31'b0, busy}, 1);
    repeat (sl) begin db_valid = 0; db_in = 8'hEE; start = sb; step; end
    db_valid = 1; db_in = lo; start = sb; step;
    if (!m[1]) begin
      repeat (sh) begin db_valid = 0; db_in = 8'hEE; start = sb; step; end
      db_valid = 1; db_in = hi; start = sb; step;
    end
    db_valid = 0;
    n = 0;
    while (busy && n < 10) begin start = sb; step; n++; end
    start = 0;
    check("done_in_budget", {31'b0, n < 10}, 1);
    check("ea_hold", {16'b0, ea}, {16'b0, xe});
    check("pc_hold", {31'b0, page_cross}, {31'b0, xp});
    check("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    step; step;
    check("rst_ea", {16'b0, ea}, 0);
    check("rst_ea_valid", {31'b0, ea_valid}, 0);
    check("rst_page_cross", {31'b0, page_cross}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    resb = 1; step;
    txn(2'b00, 8'h10, 8'h00, 8'h10, 8'h20, 8'h12, 0, 0, 0, 0, 16'h1230, 0, 3);
    txn(2'b00, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'h12, 0, 0, 0, 0, 16'h1300, 1, 4);
    txn(2'b01, 8'h00, 8'h20, 8'h00, 8'hF0, 8'hFF, 0, 0, 0, 0, 16'h0010, 1, 4);
    txn(2'b10, 8'h20, 8'h00, 8'h20, 8'hF0, 8'h00, 0, 0, 0, 0, 16'h0010, 0, 2);
    txn(2'b00, 8'h01, 8'h00, 8'h01, 8'h10, 8'h40, 0, 0, 1, 0, 16'h4011, 0, 4);
    txn(2'b00, 8'h05, 8'h00, 8'h77, 8'h00, 8'h30, 2, 1, 0, 1, 16'h3005, 0, 6);
    txn(2'b11, 8'h11, 8'h05, 8'h11, 8'h30, 8'h00, 0, 0, 0, 0, 16'h0035, 0, 2);
    txn(2'b10, 8'h03, 8'h00, 8'h03, 8'hFE, 8'h00, 0, 0, 1, 0, 16'h0001, 0, 2);
    txn(2'b01, 8'h80, 8'h7F, 8'h80, 8'h80, 8'hA5, 1, 2, 0, 1, 16'hA5FF, 0, 6);
    mode = 2'b00; index_x = 8'h01; start = 1; step;
    start = 0; db_valid = 1; db_in = 8'h20; step;
    resb = 0; db_valid = 0; step;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_ea", {16'b0, ea}, 0);
    check("midrst_ea_valid", {31'b0, ea_valid}, 0);
    check("midrst_page_cross", {31'b0, page_cross}, 0);
    resb = 1; step; step; step;
    check("midrst_idle_busy", {31'b0, busy}, 0);
    txn(2'b00, 8'h02, 8'h00, 8'h02, 8'h40, 8'h56, 0, 0, 0, 0, 16'h5642, 0, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
